// File: rtl/adder_share_arb.sv
// Round-robin sequencer that time-shares one external combinational adder
// between NREQ requesters over valid/ready request and response channels.
module adder_share_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NREQ-1:0]         req_valid_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic [NREQ*WIDTH-1:0]   req_a_i,
    input  logic [NREQ*WIDTH-1:0]   req_b_i,
    output logic [WIDTH-1:0]        add_a_o,
    output logic [WIDTH-1:0]        add_b_o,
    input  logic [WIDTH-1:0]        add_s_i,
    output logic [NREQ-1:0]         rsp_valid_o,
    input  logic [NREQ-1:0]         rsp_ready_i,
    output logic [WIDTH-1:0]        rsp_sum_o,
    output logic                    busy_o
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt;
    logic [PW-1:0]   win;
    logic            found;

    // Winner is the first valid requester after the last one served.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            int idx;
            idx = (int'(ptr) + i) % int'(NREQ);
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    // Accept is offered only while idle and out of reset.
    always_comb begin
        req_ready_o = '0;
        if (state == IDLE && !rst_i && found) begin
            req_ready_o[win] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            ptr         <= PW'(NREQ - 1);
            gnt         <= '0;
            add_a_o     <= '0;
            add_b_o     <= '0;
            rsp_sum_o   <= '0;
            rsp_valid_o <= '0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        add_a_o <= req_a_i[int'(win)*int'(WIDTH) +: WIDTH];
                        add_b_o <= req_b_i[int'(win)*int'(WIDTH) +: WIDTH];
                        gnt     <= win;
                        busy_o  <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_sum_o   <= add_s_i;
                    rsp_valid_o <= NREQ'(1) << gnt;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i[gnt]) begin
                        rsp_valid_o <= '0;
                        ptr         <= gnt;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
